// File: rtl/alu_exec_if.sv
// Execute-stage bus: sequencer handshake/status plus the register-file read and write ports.
interface alu_exec_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 1
);
  logic                  start;
  logic [2:0]            opcode;
  logic [ADDR_WIDTH-1:0] srcA;
  logic [ADDR_WIDTH-1:0] srcB;
  logic [ADDR_WIDTH-1:0] dst;
  logic [ADDR_WIDTH-1:0] readRegister1;
  logic [ADDR_WIDTH-1:0] readRegister2;
  logic [DATA_WIDTH-1:0] Out1;
  logic [DATA_WIDTH-1:0] Out2;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  busy;
  logic                  done;
  logic                  zero;
  logic                  carry;
  logic                  err;

  modport slave (
    input  start, opcode, srcA, srcB, dst, Out1, Out2,
    output readRegister1, readRegister2, writeEnable, writeRegister, writeData,
           busy, done, zero, carry, err
  );

  modport master (
    output start, opcode, srcA, srcB, dst, Out1, Out2,
    input  readRegister1, readRegister2, writeEnable, writeRegister, writeData,
           busy, done, zero, carry, err
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute stage: fetches two operands from the register file, runs an ALU op or a
// shift-add multiply, and issues exactly one write-back with done/zero/carry/err status.
module alu_exec_stage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 1
) (
  input  logic       clk,
  input  logic       resetN,
  alu_exec_if.slave  bus
);
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_AND   = 3'd2;
  localparam logic [2:0] OP_OR    = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_PASSA = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_RSV   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WB} state_t;

  state_t                r_state;
  logic [2:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_rd1, r_rd2, r_dst, r_wreg;
  logic [DATA_WIDTH-1:0] r_a, r_b, r_wdata;
  logic [PROD_W-1:0]     r_mcand, r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_we, r_busy, r_done, r_zero, r_carry, r_err;

  logic [DATA_WIDTH-1:0] w_alu, w_res;
  logic                  w_alu_carry, w_res_carry, w_err, w_mul_last, w_fin;
  logic [PROD_W-1:0]     w_prod;

  // Single-cycle ops; SUB borrow falls out as the extra top bit of the wrapped difference
  always_comb begin
    w_alu       = '0;
    w_alu_carry = 1'b0;
    case (r_op)
      OP_ADD:   {w_alu_carry, w_alu} = {1'b0, r_a} + {1'b0, r_b};
      OP_SUB:   {w_alu_carry, w_alu} = {1'b0, r_a} - {1'b0, r_b};
      OP_AND:   w_alu = r_a & r_b;
      OP_OR:    w_alu = r_a | r_b;
      OP_XOR:   w_alu = r_a ^ r_b;
      OP_PASSA: w_alu = r_a;
      default:  w_alu = '0;
    endcase
  end

  // One multiplier bit per EXEC cycle: r_b shifts right, multiplicand shifts left
  assign w_prod      = r_acc + (r_b[0] ? r_mcand : '0);
  assign w_mul_last  = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_err       = (r_op == OP_RSV);
  assign w_fin       = (r_op != OP_MUL) || w_mul_last;
  assign w_res       = (r_op == OP_MUL) ? w_prod[DATA_WIDTH-1:0] : w_alu;
  assign w_res_carry = (r_op == OP_MUL) ? (|w_prod[PROD_W-1:DATA_WIDTH]) : w_alu_carry;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_dst   <= '0;
      r_wreg  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_wdata <= '0;
      r_mcand <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.opcode;
            r_rd1   <= bus.srcA;
            r_rd2   <= bus.srcB;
            r_dst   <= bus.dst;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_a     <= bus.Out1;
          r_b     <= bus.Out2;
          r_mcand <= PROD_W'(bus.Out1);
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            r_acc   <= w_prod;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
          // Write-back outputs are registered here so they are valid for the whole WB cycle
          if (w_fin) begin
            r_we    <= !w_err;
            r_wreg  <= r_dst;
            r_wdata <= w_res;
            r_done  <= 1'b1;
            r_zero  <= (w_res == '0) && !w_err;
            r_carry <= w_res_carry && !w_err;
            r_err   <= w_err;
            r_state <= S_WB;
          end
        end
        S_WB: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.readRegister1 = r_rd1;
  assign bus.readRegister2 = r_rd2;
  assign bus.writeEnable   = r_we;
  assign bus.writeRegister = r_wreg;
  assign bus.writeData     = r_wdata;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.zero          = r_zero;
  assign bus.carry         = r_carry;
  assign bus.err           = r_err;
endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a 2-entry register file model behind it.
module tb_alu_exec_stage;
  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] rf [0:1];
  logic       pl_en = 1'b0;
  logic [7:0] pl0 = '0;
  logic [7:0] pl1 = '0;
  int         total = 0;
  int         bad = 0;
  int         pulses;

  alu_exec_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) bus ();

  alu_exec_stage #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.Out1 = rf[bus.readRegister1];
  assign bus.Out2 = rf[bus.readRegister2];

  // Register file: backdoor preload has priority, otherwise commit the write-back
  always @(posedge clk) begin
    if (pl_en) begin
      rf[0] <= pl0;
      rf[1] <= pl1;
    end else if (bus.writeEnable) begin
      rf[bus.writeRegister] <= bus.writeData;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] b);
    pl0 = a;
    pl1 = b;
    pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  // Accept at E0, then step to the edge that opens WB (E2 for ALU ops, E9 for MUL)
  task automatic go(input logic [2:0] op, input logic sa, input logic sb, input logic d,
                    input int lat);
    bus.opcode = op;
    bus.srcA   = sa;
    bus.srcB   = sb;
    bus.dst    = d;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    chk("busy_accept", 16'(bus.busy), 16'd1);
    chk("rd1_latched", 16'(bus.readRegister1), 16'(sa));
    chk("rd2_latched", 16'(bus.readRegister2), 16'(sb));
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("we_early", 16'(bus.writeEnable), 16'd0);
      chk("busy_run", 16'(bus.busy), 16'd1);
    end
    tick();
  endtask

  task automatic wb_chk(input string tag, input logic we, input logic wreg, input logic [7:0] data,
                        input logic z, input logic c, input logic e);
    chk({tag, "_we"},    16'(bus.writeEnable), 16'(we));
    chk({tag, "_done"},  16'(bus.done), 16'd1);
    chk({tag, "_busy"},  16'(bus.busy), 16'd1);
    chk({tag, "_zero"},  16'(bus.zero), 16'(z));
    chk({tag, "_carry"}, 16'(bus.carry), 16'(c));
    chk({tag, "_err"},   16'(bus.err), 16'(e));
    if (we) begin
      chk({tag, "_wreg"}, 16'(bus.writeRegister), 16'(wreg));
      chk({tag, "_data"}, 16'(bus.writeData), 16'(data));
    end
  endtask

  task automatic post(input string tag, input logic [7:0] r0, input logic [7:0] r1);
    tick();
    chk({tag, "_we_off"},   16'(bus.writeEnable), 16'd0);
    chk({tag, "_done_off"}, 16'(bus.done), 16'd0);
    chk({tag, "_idle"},     16'(bus.busy), 16'd0);
    chk({tag, "_r0"},       16'(rf[0]), 16'(r0));
    chk({tag, "_r1"},       16'(rf[1]), 16'(r1));
  endtask

  // Fresh operands, op with dst=0, check WB and the committed register
  task automatic vec(input string tag, input logic [2:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] res, input logic c);
    preload(a, b);
    go(op, 1'b0, 1'b1, 1'b0, (op == 3'd6) ? 9 : 2);
    wb_chk(tag, 1'b1, 1'b0, res, res == 8'h00, c, 1'b0);
    post(tag, res, b);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.opcode = '0;
    bus.srcA   = '0;
    bus.srcB   = '0;
    bus.dst    = '0;
    tick();
    tick();
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_we", 16'(bus.writeEnable), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_flags", 16'({bus.zero, bus.carry, bus.err}), 16'd0);
    chk("rst_wdata", 16'(bus.writeData), 16'd0);
    chk("rst_rd", 16'({bus.readRegister1, bus.readRegister2}), 16'd0);
    resetN = 1'b1;
    tick();

    // ADD r0+r1 -> r1
    preload(8'd4, 8'd5);
    go(3'd0, 1'b0, 1'b1, 1'b1, 2);
    wb_chk("add", 1'b1, 1'b1, 8'd9, 1'b0, 1'b0, 1'b0);
    post("add", 8'd4, 8'd9);
    chk("add_wdata_hold", 16'(bus.writeData), 16'd9);

    // SUB 4-5 -> r0 with borrow
    preload(8'd4, 8'd5);
    go(3'd1, 1'b0, 1'b1, 1'b0, 2);
    wb_chk("sub", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
    post("sub", 8'hFF, 8'd5);

    // MUL 0x10*0x10 = 0x100
    preload(8'h10, 8'h10);
    go(3'd6, 1'b0, 1'b1, 1'b0, 9);
    wb_chk("mul", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    post("mul", 8'h00, 8'h10);

    // XOR with srcA==srcB
    preload(8'h11, 8'h5A);
    go(3'd4, 1'b1, 1'b1, 1'b0, 2);
    wb_chk("xor_same", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    post("xor_same", 8'h00, 8'h5A);

    // Reserved opcode: no write, err set
    preload(8'd4, 8'd5);
    go(3'd7, 1'b0, 1'b1, 1'b1, 2);
    wb_chk("rsv", 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    post("rsv", 8'd4, 8'd5);

    vec("and",   3'd2, 8'hC3, 8'h5A, 8'h42, 1'b0);
    chk("err_cleared", 16'(bus.err), 16'd0);
    vec("or",    3'd3, 8'hC3, 8'h5A, 8'hDB, 1'b0);
    vec("xor",   3'd4, 8'hC3, 8'h5A, 8'h99, 1'b0);
    vec("passa", 3'd5, 8'hC3, 8'h5A, 8'hC3, 1'b0);
    vec("add_c", 3'd0, 8'hC8, 8'h64, 8'h2C, 1'b1);
    vec("sub_z", 3'd1, 8'h10, 8'h10, 8'h00, 1'b0);
    vec("mul_nc", 3'd6, 8'h0F, 8'h11, 8'hFF, 1'b0);
    vec("mul_ff", 3'd6, 8'hFF, 8'hFF, 8'h01, 1'b1);

    // Reset asserted mid-MUL: immediate drop, no write-back
    preload(8'd3, 8'd3);
    bus.opcode = 3'd6;
    bus.srcA   = 1'b0;
    bus.srcB   = 1'b1;
    bus.dst    = 1'b0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    resetN = 1'b0;
    #1;
    chk("rstmid_busy", 16'(bus.busy), 16'd0);
    chk("rstmid_we", 16'(bus.writeEnable), 16'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rstmid_we_hold", 16'(bus.writeEnable), 16'd0);
    end
    chk("rstmid_r0", 16'(rf[0]), 16'd3);
    chk("rstmid_r1", 16'(rf[1]), 16'd3);
    resetN = 1'b1;
    tick();
    go(3'd0, 1'b0, 1'b1, 1'b1, 2);
    wb_chk("after_rst", 1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b0);
    post("after_rst", 8'd3, 8'd6);

    // start held high: accept every 4th edge, three write-backs
    preload(8'd1, 8'd2);
    bus.opcode = 3'd0;
    bus.srcA   = 1'b0;
    bus.srcB   = 1'b1;
    bus.dst    = 1'b1;
    bus.start  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("held_we", 16'(bus.writeEnable), 16'((k % 4) == 2));
      chk("held_busy", 16'(bus.busy), 16'((k % 4) != 3));
      if (bus.writeEnable) begin
        chk("held_data", 16'(bus.writeData), 16'(3 + pulses));
        pulses++;
      end
    end
    bus.start = 1'b0;
    chk("held_pulses", 16'(pulses), 16'd3);
    chk("held_r1", 16'(rf[1]), 16'd5);
    tick();
    chk("held_stop", 16'(bus.busy), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
